// File: rtl/timing_sequencer_pkg.sv
// Shared definitions for the timing sequencer: state encoding and default widths.
package timing_sequencer_pkg;

  localparam int DEF_STEP_W = 4;
  localparam int DEF_CNT_W  = 8;
  localparam int NUM_STEPS  = 2 ** DEF_STEP_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } seq_state_e;

endpackage

// File: rtl/timing_sequencer_decoder.sv
// Combinational step-to-one-hot decoder; all lines low when not enabled.
module timing_decoder #(
  parameter int STEP_W = 4
) (
  input  logic [STEP_W-1:0]      step,
  input  logic                   en,
  output logic [2**STEP_W-1:0]   lines
);

  // One-hot decode of the current step, gated by the enable.
  always_comb begin
    lines = '0;
    if (en) begin
      lines[step] = 1'b1;
    end else begin
      lines = '0;
    end
  end

endmodule

// File: rtl/timing_sequencer.sv
// Multicycle timing generator: IDLE/RUN/HALTED FSM, step counter, completion count.
// Optional single-step handshake enabled by TIMING_SEQUENCER_SINGLE_STEP_EN.
module timing_sequencer
  import timing_sequencer_pkg::*;
#(
  parameter int STEP_W = DEF_STEP_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic                  Halt,
  input  logic                  Clear,
  input  logic                  Hold,
  input  logic [STEP_W-1:0]     LastStep,
`ifdef TIMING_SEQUENCER_SINGLE_STEP_EN
  input  logic                  StepReq,
  output logic                  StepAck,
`endif
  output logic [2**STEP_W-1:0]  T,
  output logic [STEP_W-1:0]     Step,
  output logic                  Busy,
  output logic                  Halted,
  output logic                  Done,
  output logic [CNT_W-1:0]      SeqCount
);

  localparam logic [STEP_W-1:0] STEP_MAX = {STEP_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  seq_state_e         state_r, state_s;
  logic [STEP_W-1:0]  step_r, step_s;
  logic               done_r, done_s;
  logic [CNT_W-1:0]   seq_count_r, seq_count_s;
  logic               advance_s;
  logic               wrap_s;
  logic               ack_s;

`ifdef TIMING_SEQUENCER_SINGLE_STEP_EN
  logic               ack_r;
  assign advance_s = StepReq;
  assign StepAck   = ack_r;
`else
  assign advance_s = 1'b1;
`endif

  // Completion point: programmed last step, or the top of the range when
  // LastStep was lowered below the current step mid-sequence.
  assign wrap_s = (step_r == LastStep) || (step_r == STEP_MAX);

  // Next-state, next-step, completion pulse and saturating count.
  always_comb begin
    state_s     = state_r;
    step_s      = step_r;
    done_s      = 1'b0;
    seq_count_s = seq_count_r;
    ack_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (Halt) begin
          state_s = ST_HALTED;
        end else if (Start) begin
          state_s = ST_RUN;
          step_s  = '0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (Halt) begin
          state_s = ST_HALTED;
          step_s  = '0;
        end else if (Clear) begin
          step_s      = '0;
          done_s      = 1'b1;
          seq_count_s = (seq_count_r == CNT_MAX) ? seq_count_r : seq_count_r + 1'b1;
        end else if (Hold) begin
          step_s = step_r;
        end else if (advance_s) begin
          ack_s = 1'b1;
          if (wrap_s) begin
            step_s      = '0;
            done_s      = 1'b1;
            seq_count_s = (seq_count_r == CNT_MAX) ? seq_count_r : seq_count_r + 1'b1;
          end else begin
            step_s = step_r + 1'b1;
          end
        end else begin
          step_s = step_r;
        end
      end
      ST_HALTED: begin
        if (Start) begin
          state_s = ST_RUN;
          step_s  = '0;
        end else begin
          state_s = ST_HALTED;
        end
      end
      default: begin
        state_s = ST_IDLE;
        step_s  = '0;
      end
    endcase
  end

  // State, step counter, completion pulse and sequence count registers.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_r     <= ST_IDLE;
      step_r      <= '0;
      done_r      <= 1'b0;
      seq_count_r <= '0;
    end else begin
      state_r     <= state_s;
      step_r      <= step_s;
      done_r      <= done_s;
      seq_count_r <= seq_count_s;
    end
  end

`ifdef TIMING_SEQUENCER_SINGLE_STEP_EN
  // Acknowledge register for single-step advances.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      ack_r <= 1'b0;
    end else begin
      ack_r <= ack_s;
    end
  end
`else
  logic unused_s;
  assign unused_s = ack_s;
`endif

  timing_decoder #(.STEP_W(STEP_W)) u_decoder (
    .step  (step_r),
    .en    (state_r == ST_RUN),
    .lines (T)
  );

  assign Step     = step_r;
  assign Busy     = (state_r == ST_RUN);
  assign Halted   = (state_r == ST_HALTED);
  assign Done     = done_r;
  assign SeqCount = seq_count_r;

endmodule

// File: tb/tb_timing_sequencer.sv
// Directed bench for timing_sequencer with a cycle model and literal spot checks.
module tb_timing_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, start, halt, clear, hold;
  logic [3:0]  last_step;
  logic [15:0] t_o;
  logic [3:0]  step_o;
  logic        busy_o, halted_o, done_o;
  logic [7:0]  cnt_o;
`ifdef TIMING_SEQUENCER_SINGLE_STEP_EN
  logic        step_req;
  logic        step_ack;
`endif

  int total = 0;
  int bad   = 0;

  // model: mode 0=idle 1=run 2=halted
  int m_mode = 0;
  int m_step = 0;
  int m_done = 0;
  int m_cnt  = 0;
  int m_ack  = 0;

  always #5 clk = ~clk;

  timing_sequencer dut (
    .Clock    (clk),
    .Reset    (rst_n),
    .Start    (start),
    .Halt     (halt),
    .Clear    (clear),
    .Hold     (hold),
    .LastStep (last_step),
`ifdef TIMING_SEQUENCER_SINGLE_STEP_EN
    .StepReq  (step_req),
    .StepAck  (step_ack),
`endif
    .T        (t_o),
    .Step     (step_o),
    .Busy     (busy_o),
    .Halted   (halted_o),
    .Done     (done_o),
    .SeqCount (cnt_o)
  );

  // Reference model evaluated from the rules at each rising edge.
  always @(posedge clk) begin
    int req;
    bit finish_seq;
`ifdef TIMING_SEQUENCER_SINGLE_STEP_EN
    req = int'(step_req);
`else
    req = 1;
`endif
    finish_seq = (m_step == int'(last_step)) || (m_step == 15);
    if (!rst_n) begin
      m_mode <= 0; m_step <= 0; m_done <= 0; m_cnt <= 0; m_ack <= 0;
    end else if (m_mode == 0) begin
      m_done <= 0; m_ack <= 0;
      if (halt) m_mode <= 2;
      else if (start) begin m_mode <= 1; m_step <= 0; end
    end else if (m_mode == 2) begin
      m_done <= 0; m_ack <= 0;
      if (start) begin m_mode <= 1; m_step <= 0; end
    end else begin
      m_done <= 0; m_ack <= 0;
      if (halt) begin
        m_mode <= 2; m_step <= 0;
      end else if (clear) begin
        m_step <= 0; m_done <= 1; m_cnt <= (m_cnt < 255) ? m_cnt + 1 : 255;
      end else if (hold) begin
        m_step <= m_step;
      end else if (req != 0) begin
        m_ack <= 1;
        if (finish_seq) begin
          m_step <= 0; m_done <= 1; m_cnt <= (m_cnt < 255) ? m_cnt + 1 : 255;
        end else begin
          m_step <= m_step + 1;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one cycle and compare every output against the model.
  task automatic tick();
    int exp_t;
    @(negedge clk);
    exp_t = (m_mode == 1) ? (1 << m_step) : 0;
    chk("T",        int'(t_o),      exp_t);
    chk("Step",     int'(step_o),   m_step);
    chk("Busy",     int'(busy_o),   (m_mode == 1) ? 1 : 0);
    chk("Halted",   int'(halted_o), (m_mode == 2) ? 1 : 0);
    chk("Done",     int'(done_o),   m_done);
    chk("SeqCount", int'(cnt_o),    m_cnt);
`ifdef TIMING_SEQUENCER_SINGLE_STEP_EN
    chk("StepAck",  int'(step_ack), m_ack);
`endif
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; halt = 1'b0; clear = 1'b0; hold = 1'b0;
    last_step = 4'd3;
`ifdef TIMING_SEQUENCER_SINGLE_STEP_EN
    step_req = 1'b1;
`endif
    ticks(2);
    chk("lit reset T", int'(t_o), 16'h0000);
    chk("lit reset cnt", int'(cnt_o), 0);
    chk("lit reset busy", int'(busy_o), 0);

    // basic sequence with LastStep=3
    rst_n = 1'b1; start = 1'b1;
    tick();
    chk("lit T0", int'(t_o), 16'h0001);
    start = 1'b0;
    tick(); chk("lit T1", int'(t_o), 16'h0002);
    tick(); chk("lit T2", int'(t_o), 16'h0004);
    tick(); chk("lit T3", int'(t_o), 16'h0008);
    tick();
    chk("lit wrap T0", int'(t_o), 16'h0001);
    chk("lit wrap done", int'(done_o), 1);
    chk("lit wrap cnt", int'(cnt_o), 1);

    // hold at step 2
    ticks(2);
    hold = 1'b1;
    ticks(3);
    chk("lit hold T", int'(t_o), 16'h0004);
    chk("lit hold step", int'(step_o), 2);
    chk("lit hold done", int'(done_o), 0);
    hold = 1'b0;
    tick(); chk("lit hold release", int'(step_o), 3);
    tick(); chk("lit cnt after hold", int'(cnt_o), 2);

    // clear together with hold at step 5
    last_step = 4'd15;
    ticks(5);
    chk("lit step5", int'(step_o), 5);
    clear = 1'b1; hold = 1'b1;
    tick();
    clear = 1'b0; hold = 1'b0;
    chk("lit clear step", int'(step_o), 0);
    chk("lit clear done", int'(done_o), 1);
    chk("lit clear cnt", int'(cnt_o), 3);

    // halt beats clear at step 7
    ticks(7);
    halt = 1'b1; clear = 1'b1;
    tick();
    halt = 1'b0; clear = 1'b0;
    chk("lit halt T", int'(t_o), 16'h0000);
    chk("lit halted", int'(halted_o), 1);
    chk("lit halt done", int'(done_o), 0);
    ticks(2);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("lit restart T", int'(t_o), 16'h0001);
    chk("lit restart cnt", int'(cnt_o), 3);

    // LastStep lowered below current step
    ticks(10);
    last_step = 4'd4;
    ticks(5);
    chk("lit step15", int'(step_o), 15);
    tick();
    chk("lit over wrap done", int'(done_o), 1);
    chk("lit over wrap cnt", int'(cnt_o), 4);

    // saturation via back-to-back completions
    last_step = 4'd0;
    ticks(260);
    chk("lit sat cnt", int'(cnt_o), 255);
    chk("lit sat done", int'(done_o), 1);

    // reset mid-sequence
    last_step = 4'd15;
    ticks(6);
    chk("lit step6", int'(step_o), 6);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("lit mid reset T", int'(t_o), 16'h0000);
    chk("lit mid reset cnt", int'(cnt_o), 0);
    chk("lit mid reset busy", int'(busy_o), 0);
    tick();

    // halt has priority over start in idle
    halt = 1'b1; start = 1'b1;
    tick();
    halt = 1'b0;
    chk("lit idle halt", int'(halted_o), 1);
    tick();
    start = 1'b0;
    chk("lit halted start", int'(t_o), 16'h0001);
    ticks(3);

`ifdef TIMING_SEQUENCER_SINGLE_STEP_EN
    step_req = 1'b0;
    ticks(3);
    chk("lit ss hold", int'(step_o), 3);
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    chk("lit ss adv", int'(step_o), 4);
    chk("lit ss ack", int'(step_ack), 1);
    tick();
    chk("lit ss ack low", int'(step_ack), 0);
    chk("lit ss stay", int'(step_o), 4);
    step_req = 1'b1;
    ticks(2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
